cic_decim_mc: RTL and testbench

Parametrised multi-channel CIC decimator for 1-bit PDM microphone streams, sitting between the I2S/PDM deserialiser and the uDMA RX path.
- Channels arrive time-multiplexed on one bit input. Per-channel integrator and comb state is held in register arrays.
- Over the fixed-configuration decimator it adds: generic stage/channel/width counts, a 1-bit-granular output window with rounding, a valid/ready output with channel tag, and sticky overflow reporting.

---
 rtl/cic_decim_mc.sv | 208 ++++++++++++++++++++
 tb/tb_cic_decim_mc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// rtl/cic_decim_mc.sv - multi-channel CIC decimator for 1-bit PDM streams; define CIC_SAT_EN to saturate the output window
module cic_decim_mc #(
  parameter int STAGES      = 5,
  parameter int MAX_CH      = 4,
  parameter int ACC_WIDTH   = 51,
  parameter int DEC_WIDTH   = 10,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_en_i,
  input  logic [$clog2(MAX_CH)-1:0]  cfg_ch_num_i,
  input  logic [DEC_WIDTH-1:0]       cfg_decimation_i,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift_i,
  input  logic                       cfg_clr_ovf_i,
  input  logic                       data_i,
  input  logic                       data_valid_i,
  output logic [OUT_WIDTH-1:0]       data_o,
  output logic [$clog2(MAX_CH)-1:0]  data_ch_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic                       overflow_o
);

  localparam int CH_W      = $clog2(MAX_CH);
  localparam int MAX_SHIFT = ACC_WIDTH - OUT_WIDTH;

  typedef logic [ACC_WIDTH-1:0] acc_t;

  logic                   r_en;
  logic                   s_clr;
  logic                   s_acc;
  logic                   s_hit;
  logic                   s_hs;
  logic                   s_load;
  logic                   s_drop;
  logic [CH_W-1:0]        r_ch;
  logic [CH_W-1:0]        s_ch_last;
  logic [DEC_WIDTH-1:0]   r_smp;
  acc_t                   r_int [STAGES][MAX_CH];
  acc_t                   r_dly [STAGES][MAX_CH];
  acc_t                   s_c   [STAGES+1];
  acc_t                   s_x;
  acc_t                   s_round;
  acc_t                   s_r;
  logic [SHIFT_WIDTH-1:0] s_shift;
  logic [OUT_WIDTH-1:0]   s_win;
  logic [OUT_WIDTH-1:0]   s_pcm;
  logic [OUT_WIDTH-1:0]   r_data;
  logic [CH_W-1:0]        r_data_ch;
  logic                   r_valid;
  logic                   r_ovf;

  // enable edge detector: a fresh enable restarts the filter from zero state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en <= 1'b0;
    end else begin
      r_en <= cfg_en_i;
    end
  end

  assign s_clr = cfg_en_i & ~r_en;
  assign s_acc = cfg_en_i & ~s_clr & data_valid_i;
  assign s_hit = s_acc & (r_smp == cfg_decimation_i);
  assign s_x   = data_i ? acc_t'(1) : '1;

  // last active channel, capped so out-of-range configs never address missing state
  always_comb begin
    s_ch_last = cfg_ch_num_i;
    if ({1'b0, cfg_ch_num_i} >= (CH_W+1)'(MAX_CH)) begin
      s_ch_last = CH_W'(MAX_CH - 1);
    end
  end

  // channel slot and frame counters; the frame counter picks the decimation instant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ch  <= '0;
      r_smp <= '0;
    end else if (s_clr) begin
      r_ch  <= '0;
      r_smp <= '0;
    end else if (s_acc) begin
      if (r_ch >= s_ch_last) begin
        r_ch  <= '0;
        r_smp <= (r_smp == cfg_decimation_i) ? '0 : r_smp + 1'b1;
      end else begin
        r_ch  <= r_ch + 1'b1;
      end
    end
  end

  // pipelined integrator cascade: each stage accumulates the previous stage's old value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < MAX_CH; c++) begin
          r_int[k][c] <= '0;
        end
      end
    end else if (s_clr) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < MAX_CH; c++) begin
          r_int[k][c] <= '0;
        end
      end
    end else if (s_acc) begin
      r_int[0][r_ch] <= r_int[0][r_ch] + s_x;
      for (int k = 1; k < STAGES; k++) begin
        r_int[k][r_ch] <= r_int[k][r_ch] + r_int[k-1][r_ch];
      end
    end
  end

  // comb chain evaluated in one cycle from the last integrator's pre-update value
  always_comb begin
    s_c[0] = r_int[STAGES-1][r_ch];
    for (int k = 1; k <= STAGES; k++) begin
      s_c[k] = s_c[k-1] - r_dly[k-1][r_ch];
    end
  end

  // comb delay elements capture each stage input at the decimation instant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < MAX_CH; c++) begin
          r_dly[k][c] <= '0;
        end
      end
    end else if (s_clr) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int c = 0; c < MAX_CH; c++) begin
          r_dly[k][c] <= '0;
        end
      end
    end else if (s_hit) begin
      for (int k = 0; k < STAGES; k++) begin
        r_dly[k][r_ch] <= s_c[k];
      end
    end
  end

  // output window: clamp shift, round half up, then slice (or saturate)
  always_comb begin
    s_shift = cfg_shift_i;
    if (int'(cfg_shift_i) > MAX_SHIFT) begin
      s_shift = SHIFT_WIDTH'(MAX_SHIFT);
    end
    s_round = '0;
    if (s_shift != '0) begin
      s_round = acc_t'(1) << (s_shift - 1'b1);
    end
    s_r   = s_c[STAGES] + s_round;
    s_win = OUT_WIDTH'(s_r >> s_shift);
    s_pcm = s_win;
`ifdef CIC_SAT_EN
    begin
      acc_t s_hi;
      s_hi = acc_t'($signed(s_r) >>> (32'(s_shift) + OUT_WIDTH - 1));
      if ((s_hi != '0) && (s_hi != '1)) begin
        s_pcm = s_r[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
`endif
  end

  assign s_hs   = r_valid & data_ready_i;
  assign s_drop = s_hit & r_valid & ~data_ready_i;
  assign s_load = s_hit & ~s_drop;

  // output holding register with valid/ready and sticky drop flag (set beats clear)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data    <= '0;
      r_data_ch <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (s_clr) begin
      r_data    <= '0;
      r_data_ch <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (s_load) begin
        r_data    <= s_pcm;
        r_data_ch <= r_ch;
        r_valid   <= 1'b1;
      end else if (s_hs) begin
        r_valid   <= 1'b0;
      end
      if (s_drop) begin
        r_ovf <= 1'b1;
      end else if (cfg_clr_ovf_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign data_ch_o    = r_data_ch;
  assign data_valid_o = r_valid;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_cic_decim_mc.sv
// tb/tb_cic_decim_mc.sv - randomized self-checking bench for cic_decim_mc against a closed-form CIC model
module tb_cic_decim_mc;

  localparam int STAGES      = 5;
  localparam int MAX_CH      = 4;
  localparam int ACC_WIDTH   = 51;
  localparam int DEC_WIDTH   = 10;
  localparam int OUT_WIDTH   = 16;
  localparam int SHIFT_WIDTH = 6;
  localparam int CH_W        = $clog2(MAX_CH);

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   cfg_en_i;
  logic [CH_W-1:0]        cfg_ch_num_i;
  logic [DEC_WIDTH-1:0]   cfg_decimation_i;
  logic [SHIFT_WIDTH-1:0] cfg_shift_i;
  logic                   cfg_clr_ovf_i;
  logic                   data_i;
  logic                   data_valid_i;
  logic [OUT_WIDTH-1:0]   data_o;
  logic [CH_W-1:0]        data_ch_o;
  logic                   data_valid_o;
  logic                   data_ready_i;
  logic                   overflow_o;

  always #5 clk_i = ~clk_i;

  cic_decim_mc #(
    .STAGES(STAGES), .MAX_CH(MAX_CH), .ACC_WIDTH(ACC_WIDTH),
    .DEC_WIDTH(DEC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_ch_num_i(cfg_ch_num_i),
    .cfg_decimation_i(cfg_decimation_i), .cfg_shift_i(cfg_shift_i),
    .cfg_clr_ovf_i(cfg_clr_ovf_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o), .data_ch_o(data_ch_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .overflow_o(overflow_o)
  );

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s.%s: observed 0x%0h, expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  // reference state: per-channel input history and the expected output register
  int                   hist [MAX_CH][$];
  int                   m_cnt;
  logic                 m_en_q;
  logic                 m_valid;
  logic                 m_ovf;
  logic [OUT_WIDTH-1:0] m_data;
  logic [CH_W-1:0]      m_ch;
  int                   n_out;
  logic [OUT_WIDTH-1:0] last_data [MAX_CH];
  logic [CH_W-1:0]      last_ch;

  function automatic void model_clear();
    for (int c = 0; c < MAX_CH; c++) hist[c].delete();
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_data  = '0;
    m_ch    = '0;
  endfunction

  function automatic longint binom(input longint n, input int k);
    longint r;
    if (n < 0 || n < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // N-fold running sum seen before sample t: sum_j C(t-1-j, N-1) * x_j
  function automatic longint integ_n(input int c, input int t);
    longint acc;
    acc = 0;
    for (int j = 0; j < t; j++) acc += binom(t - 1 - j, STAGES - 1) * hist[c][j];
    return acc;
  endfunction

  // N-th difference of the decimated integrator sequence (zero before the first hit)
  function automatic longint comb_out(input int c, input int m, input int rr);
    longint acc;
    acc = 0;
    for (int k = 0; k <= STAGES; k++) begin
      if (m - k >= 0) acc += ((k % 2) ? -1 : 1) * binom(STAGES, k) * integ_n(c, (m - k) * rr + rr - 1);
    end
    return acc;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] scale(input longint cn, input int shv);
    int                   s;
    longint               r;
    logic [OUT_WIDTH-1:0] w;
    s = (shv > ACC_WIDTH - OUT_WIDTH) ? ACC_WIDTH - OUT_WIDTH : shv;
    r = cn + ((s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0));
    w = OUT_WIDTH'(r >>> s);
`ifdef CIC_SAT_EN
    if ((r >>> (s + OUT_WIDTH - 1)) != 0 && (r >>> (s + OUT_WIDTH - 1)) != -1)
      w = (r < 0) ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
`endif
    return w;
  endfunction

  // one clock: drive at negedge, advance the model, compare shortly after posedge
  task automatic step(input logic d, input logic v, input logic rdy, input logic clr_ovf);
    logic                 hit;
    logic                 hs;
    logic                 drop;
    logic [OUT_WIDTH-1:0] nd;
    int                   nch;
    int                   rr;
    int                   c;
    int                   n;
    @(negedge clk_i);
    data_i = d; data_valid_i = v; data_ready_i = rdy; cfg_clr_ovf_i = clr_ovf;
    hit = 1'b0; nd = '0; c = 0;
    nch = int'(cfg_ch_num_i) + 1;
    if (nch > MAX_CH) nch = MAX_CH;
    rr = int'(cfg_decimation_i) + 1;
    if (cfg_en_i && !m_en_q) begin
      model_clear();
    end else begin
      if (cfg_en_i && v) begin
        c = m_cnt % nch;
        n = m_cnt / nch;
        if (n % rr == rr - 1) begin
          hit = 1'b1;
          nd  = scale(comb_out(c, n / rr, rr), int'(cfg_shift_i));
        end
        hist[c].push_back(d ? 1 : -1);
        m_cnt++;
      end
      hs   = m_valid && rdy;
      drop = hit && m_valid && !rdy;
      if (hit && !drop) begin
        m_valid = 1'b1; m_data = nd; m_ch = CH_W'(c);
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
    m_en_q = cfg_en_i;
    @(posedge clk_i);
    #1;
    check_eq("valid", data_valid_o, m_valid);
    check_eq("ovf", overflow_o, m_ovf);
    if (m_valid) begin
      check_eq("data", data_o, m_data);
      check_eq("ch", data_ch_o, m_ch);
    end
    if (data_valid_o === 1'b1 && rdy) begin
      n_out++;
      last_data[data_ch_o] = data_o;
      last_ch = data_ch_o;
    end
  endtask

  // enable-edge restart, then nsteps cycles of a stimulus pattern with ready held high
  task automatic run(input string name, input int chn, input int dec, input int shv,
                     input int pat, input int nsteps);
    int   nch;
    int   c;
    int   n;
    logic d;
    logic v;
    phase            = name;
    cfg_ch_num_i     = CH_W'(chn);
    cfg_decimation_i = DEC_WIDTH'(dec);
    cfg_shift_i      = SHIFT_WIDTH'(shv);
    cfg_en_i         = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_en_i = 1'b1;
    n_out    = 0;
    for (int i = 0; i < MAX_CH; i++) last_data[i] = 'x;
    last_ch  = 'x;
    nch = chn + 1;
    for (int i = 0; i < nsteps; i++) begin
      c = m_cnt % nch;
      n = m_cnt / nch;
      v = 1'b1;
      case (pat)
        0:       d = 1'b1;
        1:       d = (n % 2 == 0);
        2:       d = (c == 0);
        default: begin
          d = 1'($urandom_range(0, 1));
          v = ($urandom_range(0, 3) != 0);
        end
      endcase
      step(d, v, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_ch_num_i = '0; cfg_decimation_i = '0;
    cfg_shift_i = '0; cfg_clr_ovf_i = 1'b0; data_i = 1'b0; data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    m_en_q = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1;
    phase = "reset";
    check_eq("data", data_o, 0);
    check_eq("ch", data_ch_o, 0);
    check_eq("valid", data_valid_o, 0);
    check_eq("ovf", overflow_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run("plan_a", 0, 31, 11, 0, 257);
    check_eq("n_out", n_out, 8);
    check_eq("steady", last_data[0], 16'h4000);

    run("plan_shift10", 0, 31, 10, 0, 257);
`ifdef CIC_SAT_EN
    check_eq("steady", last_data[0], 16'h7fff);
`else
    check_eq("steady", last_data[0], 16'h8000);
`endif

    run("plan_alt", 0, 31, 11, 1, 321);
    check_eq("steady", last_data[0], 16'h0000);

    run("plan_2ch", 1, 31, 11, 2, 513);
    check_eq("n_out", n_out, 16);
    check_eq("steady_ch0", last_data[0], 16'h4000);
    check_eq("steady_ch1", last_data[1], 16'hc000);
    check_eq("last_ch", last_ch, 1);

    for (int it = 0; it < 6; it++) begin
      run($sformatf("rand%0d", it), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
          int'($urandom_range(0, 63)), 3, 300);
    end

    // back-pressure: drop while full, handshake, clear, load-on-handshake, set beats clear
    phase            = "bp";
    cfg_ch_num_i     = '0;
    cfg_decimation_i = DEC_WIDTH'(3);
    cfg_shift_i      = SHIFT_WIDTH'(2);
    cfg_en_i         = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_en_i = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b1, (n == 8 || n == 15), (n == 9 || n == 19));
      if (n == 7)  check_eq("ovf_after_drop", overflow_o, 1);
      if (n == 9)  check_eq("ovf_after_clr", overflow_o, 0);
      if (n == 15) check_eq("ovf_load_on_hs", overflow_o, 0);
      if (n == 19) check_eq("ovf_set_wins", overflow_o, 1);
    end

    phase = "async_rst";
    #2 rst_i = 1'b1;
    #1;
    check_eq("data", data_o, 0);
    check_eq("ch", data_ch_o, 0);
    check_eq("valid", data_valid_o, 0);
    check_eq("ovf", overflow_o, 0);
    model_clear();
    m_en_q = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    run("plan_a_again", 0, 31, 11, 0, 257);
    check_eq("n_out", n_out, 8);
    check_eq("steady", last_data[0], 16'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
